// File: rtl/stack_controller.sv
// Stack operation sequencer: drives the stack_pointer strobes and the RAM port
// for INIT/PUSH/POP/CALL/RET, with bound checking in place of memory corruption.
module stack_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] STACK_TOP    = 16'h01FF,
    parameter logic [ADDR_WIDTH-1:0] STACK_BOTTOM = 16'h0100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [ADDR_WIDTH-1:0] target_in,
    input  logic [ADDR_WIDTH-1:0] sp_in,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  sp_increment,
    output logic                  sp_decrement,
    output logic                  sp_load,
    output logic [ADDR_WIDTH-1:0] sp_load_value,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  pc_load,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] CALL_MIN = STACK_BOTTOM + 1'b1;
    localparam logic [ADDR_WIDTH-1:0] RET_MAX  = STACK_TOP - 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_PUSH,
        S_POP_INC,
        S_POP_RD,
        S_POP_CAP,
        S_CALL_HI,
        S_CALL_LO,
        S_RET_INC,
        S_RET_RDL,
        S_RET_CAPL,
        S_RET_RDH,
        S_RET_CAPH,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_spInc;
    logic                  r_spDec;
    logic                  r_spLoad;
    logic                  r_memWe;
    logic                  r_memRe;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic [ADDR_WIDTH-1:0] r_pcOut;
    logic                  r_pcLoad;
    logic                  r_done;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_target;
    logic [DATA_WIDTH-1:0] r_retLo;
    logic                  w_legal;

    // Bounds are judged on the SP value present at the accepting edge.
    always_comb begin
        w_legal = 1'b0;
        case (op)
            3'd0:    w_legal = 1'b1;
            3'd1:    w_legal = (sp_in >= STACK_BOTTOM);
            3'd2:    w_legal = (sp_in < STACK_TOP);
            3'd3:    w_legal = (sp_in >= CALL_MIN);
            3'd4:    w_legal = (sp_in <= RET_MAX);
            default: w_legal = 1'b0;
        endcase
    end

    // Outputs are set on entry to the state they belong to, so they are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_spInc    <= 1'b0;
            r_spDec    <= 1'b0;
            r_spLoad   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memRe    <= 1'b0;
            r_memWdata <= '0;
            r_dataOut  <= '0;
            r_pcOut    <= '0;
            r_pcLoad   <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_pc       <= '0;
            r_target   <= '0;
            r_retLo    <= '0;
        end else begin
            r_spInc    <= 1'b0;
            r_spDec    <= 1'b0;
            r_spLoad   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memRe    <= 1'b0;
            r_memWdata <= '0;
            r_pcLoad   <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc     <= pc_in;
                        r_target <= target_in;
                        r_error  <= 1'b0;
                        if (!w_legal) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                        end else begin
                            case (op)
                                3'd0: begin
                                    r_state  <= S_INIT;
                                    r_spLoad <= 1'b1;
                                end
                                3'd1: begin
                                    r_state    <= S_PUSH;
                                    r_memWe    <= 1'b1;
                                    r_memWdata <= data_in;
                                    r_spDec    <= 1'b1;
                                end
                                3'd2: begin
                                    r_state <= S_POP_INC;
                                    r_spInc <= 1'b1;
                                end
                                3'd3: begin
                                    r_state    <= S_CALL_HI;
                                    r_memWe    <= 1'b1;
                                    r_memWdata <= pc_in[2*DATA_WIDTH-1:DATA_WIDTH];
                                    r_spDec    <= 1'b1;
                                end
                                default: begin
                                    r_state <= S_RET_INC;
                                    r_spInc <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_INIT, S_PUSH: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_POP_INC: begin
                    r_state <= S_POP_RD;
                    r_memRe <= 1'b1;
                end
                S_POP_RD: begin
                    r_state <= S_POP_CAP;
                end
                S_POP_CAP: begin
                    r_dataOut <= mem_rdata;
                    r_state   <= S_DONE;
                    r_done    <= 1'b1;
                end
                S_CALL_HI: begin
                    r_state    <= S_CALL_LO;
                    r_memWe    <= 1'b1;
                    r_memWdata <= r_pc[DATA_WIDTH-1:0];
                    r_spDec    <= 1'b1;
                end
                S_CALL_LO: begin
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    r_pcLoad <= 1'b1;
                    r_pcOut  <= r_target;
                end
                S_RET_INC: begin
                    r_state <= S_RET_RDL;
                    r_memRe <= 1'b1;
                end
                S_RET_RDL: begin
                    r_state <= S_RET_CAPL;
                    r_spInc <= 1'b1;
                end
                S_RET_CAPL: begin
                    r_retLo <= mem_rdata;
                    r_state <= S_RET_RDH;
                    r_memRe <= 1'b1;
                end
                S_RET_RDH: begin
                    r_state <= S_RET_CAPH;
                end
                S_RET_CAPH: begin
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    r_pcLoad <= 1'b1;
                    r_pcOut  <= {mem_rdata, r_retLo};
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sp_increment  = r_spInc;
    assign sp_decrement  = r_spDec;
    assign sp_load       = r_spLoad;
    assign sp_load_value = STACK_TOP;
    assign mem_we        = r_memWe;
    assign mem_re        = r_memRe;
    assign mem_wdata     = r_memWdata;
    assign mem_addr      = (r_memWe || r_memRe) ? sp_in : '0;
    assign data_out      = r_dataOut;
    assign pc_out        = r_pcOut;
    assign pc_load       = r_pcLoad;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign error         = r_error;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: behavioural stack_pointer and synchronous RAM
// around the DUT, a vector table of operations, and hand-written corner sequences.
module tb_stack_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [7:0]  data_in = 8'h00;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] target_in = 16'h0000;
    logic [15:0] sp_in;
    logic [7:0]  mem_rdata;
    logic        sp_increment, sp_decrement, sp_load;
    logic [15:0] sp_load_value, mem_addr;
    logic        mem_we, mem_re;
    logic [7:0]  mem_wdata, data_out;
    logic [15:0] pc_out;
    logic        pc_load, busy, done, error;

    logic [15:0] spModel = 16'h0000;
    logic        spForceReq = 1'b0;
    logic [15:0] spForceVal = 16'h0000;
    logic [7:0]  ram [0:65535];
    logic [7:0]  ramRdata = 8'h00;

    int nChecks = 0;
    int nFails  = 0;

    stack_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .data_in      (data_in),
        .pc_in        (pc_in),
        .target_in    (target_in),
        .sp_in        (sp_in),
        .mem_rdata    (mem_rdata),
        .sp_increment (sp_increment),
        .sp_decrement (sp_decrement),
        .sp_load      (sp_load),
        .sp_load_value(sp_load_value),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_wdata    (mem_wdata),
        .data_out     (data_out),
        .pc_out       (pc_out),
        .pc_load      (pc_load),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    assign sp_in     = spModel;
    assign mem_rdata = ramRdata;

    // Stand-in for the stack_pointer, with a bench-side override to place SP anywhere.
    always @(posedge clk) begin
        if (spForceReq)        spModel <= spForceVal;
        else if (sp_load)      spModel <= sp_load_value;
        else if (sp_increment) spModel <= spModel + 16'd1;
        else if (sp_decrement) spModel <= spModel - 16'd1;
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) ramRdata <= ram[mem_addr];
    end

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  dataIn;
        logic [15:0] pcIn;
        logic [15:0] targetIn;
        bit          forceSp;
        logic [15:0] spVal;
        int          expCycles;
        bit          expError;
        logic [7:0]  expData;
        int          expPcLoads;
        logic [15:0] expPcOut;
        logic [15:0] expSp;
        int          expWe;
        int          expRe;
        int          expSpStr;
        bit          checkMem;
        logic [15:0] memAddr;
        logic [7:0]  memVal;
    } vec_t;

    vec_t vecs [15];

    int          rDoneCycle, rWe, rRe, rSpStr, rPcLoads, rBad, rExtra;
    bit          rError, rIdleAfter;
    logic [15:0] rPcOut;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic forceSp(input logic [15:0] v);
        @(negedge clk);
        spForceReq = 1'b1;
        spForceVal = v;
        @(posedge clk);
        #1 spForceReq = 1'b0;
    endtask

    // Issues one request and watches every cycle until done (bounded), plus one cycle after.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] d,
                                 input logic [15:0] pc, input logic [15:0] tgt,
                                 input bit holdStart);
        rDoneCycle = 0; rWe = 0; rRe = 0; rSpStr = 0; rPcLoads = 0; rBad = 0;
        rError = 1'b0; rPcOut = 16'h0000; rExtra = 0;
        @(negedge clk);
        op = o; data_in = d; pc_in = pc; target_in = tgt; start = 1'b1;
        @(posedge clk);
        #1 if (!holdStart) start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (mem_we) rWe++;
            if (mem_re) rRe++;
            rSpStr += int'(sp_increment) + int'(sp_decrement) + int'(sp_load);
            if ((int'(sp_increment) + int'(sp_decrement) + int'(sp_load)) > 1) rBad++;
            if (mem_we && mem_re) rBad++;
            if ((mem_we || mem_re) && mem_addr !== spModel) rBad++;
            if (!(mem_we || mem_re) && mem_addr !== 16'h0000) rBad++;
            if (!busy) rBad++;
            if (pc_load) begin
                rPcLoads++;
                rPcOut = pc_out;
            end
            if (done) begin
                rDoneCycle = n;
                rError     = error;
                start      = 1'b0;
                break;
            end
        end
        @(negedge clk);
        rIdleAfter = !busy && !done;
        if (mem_we || mem_re || sp_increment || sp_decrement || sp_load || pc_load) rExtra++;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2, 1'b0, 8'h00, 0, 16'h0000, 16'h01FF, 0, 0, 1, 1'b0, 16'h0000, 8'h00};
        vecs[1]  = '{3'd1, 8'hA5, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2, 1'b0, 8'h00, 0, 16'h0000, 16'h01FE, 1, 0, 1, 1'b1, 16'h01FF, 8'hA5};
        vecs[2]  = '{3'd2, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4, 1'b0, 8'hA5, 0, 16'h0000, 16'h01FF, 0, 1, 1, 1'b0, 16'h0000, 8'h00};
        vecs[3]  = '{3'd3, 8'h00, 16'h1234, 16'h8000, 1'b0, 16'h0000, 3, 1'b0, 8'hA5, 1, 16'h8000, 16'h01FD, 2, 0, 2, 1'b1, 16'h01FF, 8'h12};
        vecs[4]  = '{3'd4, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 6, 1'b0, 8'hA5, 1, 16'h1234, 16'h01FF, 0, 2, 2, 1'b1, 16'h01FE, 8'h34};
        vecs[5]  = '{3'd2, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 1'b1, 8'hA5, 0, 16'h0000, 16'h01FF, 0, 0, 0, 1'b0, 16'h0000, 8'h00};
        vecs[6]  = '{3'd6, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 1'b1, 8'hA5, 0, 16'h0000, 16'h01FF, 0, 0, 0, 1'b0, 16'h0000, 8'h00};
        vecs[7]  = '{3'd4, 8'h00, 16'h0000, 16'h0000, 1'b1, 16'h01FE, 1, 1'b1, 8'hA5, 0, 16'h0000, 16'h01FE, 0, 0, 0, 1'b0, 16'h0000, 8'h00};
        vecs[8]  = '{3'd3, 8'h00, 16'hABCD, 16'h4321, 1'b1, 16'h0101, 3, 1'b0, 8'hA5, 1, 16'h4321, 16'h00FF, 2, 0, 2, 1'b1, 16'h0100, 8'hCD};
        vecs[9]  = '{3'd3, 8'h00, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1, 1'b1, 8'hA5, 0, 16'h0000, 16'h00FF, 0, 0, 0, 1'b0, 16'h0000, 8'h00};
        vecs[10] = '{3'd1, 8'h3C, 16'h0000, 16'h0000, 1'b1, 16'h0100, 2, 1'b0, 8'hA5, 0, 16'h0000, 16'h00FF, 1, 0, 1, 1'b1, 16'h0100, 8'h3C};
        vecs[11] = '{3'd1, 8'h5A, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 1'b1, 8'hA5, 0, 16'h0000, 16'h00FF, 0, 0, 0, 1'b1, 16'h00FF, 8'hXX};
        vecs[12] = '{3'd2, 8'h00, 16'h0000, 16'h0000, 1'b1, 16'h0100, 4, 1'b0, 8'hAB, 0, 16'h0000, 16'h0101, 0, 1, 1, 1'b0, 16'h0000, 8'h00};
        vecs[13] = '{3'd4, 8'h00, 16'h0000, 16'h0000, 1'b1, 16'h01FD, 6, 1'b0, 8'hAB, 1, 16'h1234, 16'h01FF, 0, 2, 2, 1'b0, 16'h0000, 8'h00};
        vecs[14] = '{3'd7, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 1'b1, 8'hAB, 0, 16'h0000, 16'h01FF, 0, 0, 0, 1'b0, 16'h0000, 8'h00};

        #12;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset error", 32'(error), 32'd0);
        checkOutput("reset data_out", 32'(data_out), 32'd0);
        checkOutput("reset pc_out", 32'(pc_out), 32'd0);
        checkOutput("reset strobes", {26'd0, sp_increment, sp_decrement, sp_load, mem_we, mem_re, pc_load}, 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("sp_load_value", 32'(sp_load_value), 32'h01FF);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].forceSp) forceSp(vecs[i].spVal);
            applyStimulus(vecs[i].op, vecs[i].dataIn, vecs[i].pcIn, vecs[i].targetIn, 1'b0);
            checkOutput($sformatf("v%0d done cycle", i), 32'(rDoneCycle), 32'(vecs[i].expCycles));
            checkOutput($sformatf("v%0d error", i), 32'(rError), 32'(vecs[i].expError));
            checkOutput($sformatf("v%0d data_out", i), 32'(data_out), 32'(vecs[i].expData));
            checkOutput($sformatf("v%0d pc_load count", i), 32'(rPcLoads), 32'(vecs[i].expPcLoads));
            if (vecs[i].expPcLoads > 0)
                checkOutput($sformatf("v%0d pc_out", i), 32'(rPcOut), 32'(vecs[i].expPcOut));
            checkOutput($sformatf("v%0d sp", i), 32'(spModel), 32'(vecs[i].expSp));
            checkOutput($sformatf("v%0d mem_we count", i), 32'(rWe), 32'(vecs[i].expWe));
            checkOutput($sformatf("v%0d mem_re count", i), 32'(rRe), 32'(vecs[i].expRe));
            checkOutput($sformatf("v%0d sp strobes", i), 32'(rSpStr), 32'(vecs[i].expSpStr));
            checkOutput($sformatf("v%0d protocol violations", i), 32'(rBad), 32'd0);
            checkOutput($sformatf("v%0d idle after done", i), 32'(rIdleAfter), 32'd1);
            checkOutput($sformatf("v%0d strobes after done", i), 32'(rExtra), 32'd0);
            if (vecs[i].checkMem && vecs[i].expWe > 0)
                checkOutput($sformatf("v%0d ram", i), 32'(ram[vecs[i].memAddr]), 32'(vecs[i].memVal));
        end

        // start held high throughout a CALL must yield exactly one sequence.
        forceSp(16'h01FF);
        applyStimulus(3'd3, 8'h00, 16'h5566, 16'h9999, 1'b1);
        checkOutput("hold done cycle", 32'(rDoneCycle), 32'd3);
        checkOutput("hold mem_we count", 32'(rWe), 32'd2);
        checkOutput("hold pc_out", 32'(rPcOut), 32'h9999);
        checkOutput("hold sp", 32'(spModel), 32'h01FD);
        rExtra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy || done || mem_we) rExtra++;
        end
        checkOutput("hold no second sequence", 32'(rExtra), 32'd0);

        // Reset arriving in the middle of a RET aborts it on the spot.
        forceSp(16'h01FD);
        @(negedge clk);
        op = 3'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("ret_rdh mem_re", 32'(mem_re), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset strobes", {26'd0, sp_increment, sp_decrement, sp_load, mem_we, mem_re, pc_load}, 32'd0);
        checkOutput("midreset outputs", {done, error, 6'd0, data_out, pc_out}, 32'd0);
        @(negedge clk);
        checkOutput("midreset held", {busy, done, mem_re, sp_increment}, 32'd0);
        reset = 1'b0;
        forceSp(16'h01FF);
        applyStimulus(3'd1, 8'h77, 16'h0000, 16'h0000, 1'b0);
        checkOutput("post-reset push done cycle", 32'(rDoneCycle), 32'd2);
        checkOutput("post-reset push error", 32'(rError), 32'd0);
        checkOutput("post-reset push ram", 32'(ram[16'h01FF]), 32'h77);
        checkOutput("post-reset push sp", 32'(spModel), 32'h01FE);
        checkOutput("post-reset push violations", 32'(rBad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
